// File: rtl/tqvp_waveform_capture_plotter.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_waveform_capture_plotter
// Brief    : Triggered multi-channel sample capture rendered as per-channel
//            page tracks on an SSD1306 OLED over SPI.
// Revision : 1.0  initial release
// ============================================================================
module tqvp_waveform_capture_plotter #(
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 128,
    parameter int PAGE_BASE = 0,
    parameter bit SPI_CPOL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_ARMED = 2'd1,
        C_RUN   = 2'd2,
        C_DONE  = 2'd3
    } cap_state_t;

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_LOAD  = 3'd1,
        R_SHIFT = 3'd2,
        R_GAP   = 3'd3,
        R_DONE  = 3'd4
    } rnd_state_t;

    // configuration registers
    logic [3:0]  r_presc_cfg;
    logic        r_mark;
    logic [4:0]  r_trig;
    logic [7:0]  r_sdiv;
    logic        r_auto;
    logic        r_man_dc;
    logic        r_man_cs_n;
    logic [7:0]  r_raw_byte;

    // capture side
    cap_state_t        r_cstate;
    logic              r_captured;
    logic [AW-1:0]     r_widx;
    logic [7:0]        r_div;
    logic [7:0]        r_prev_ui;
    logic [NUM_CH-1:0] r_mem [DEPTH];

    // render / SPI side
    rnd_state_t        r_rstate;
    logic              r_sck;
    logic [7:0]        r_shreg;
    logic              r_cs_n;
    logic              r_dc;
    logic [3:0]        r_presc_act;
    logic [3:0]        r_cnt;
    logic [3:0]        r_half;
    logic [CHW-1:0]    r_ch;
    logic              r_phase;
    logic [AW-1:0]     r_idx;
    logic              r_raw;
    logic              r_last;

    logic w_wr_ctrl, w_arm, w_render, w_abort;
    logic w_rnd_idle, w_arm_ok, w_render_ok, w_auto_go, w_raw_ok;
    logic w_edge, w_fire, w_sample_due, w_store, w_last_byte, w_idle, w_armed;
    logic w_cur_s, w_prev_s;
    logic [3:0]    w_presc_next;
    logic [AW-1:0] w_idx_prev;
    logic [7:0]    w_byte;

    assign w_wr_ctrl  = data_write && (address == 4'h0);
    assign w_arm      = w_wr_ctrl && data_in[0];
    assign w_render   = w_wr_ctrl && data_in[1];
    assign w_abort    = w_wr_ctrl && data_in[3];
    assign w_rnd_idle = (r_rstate == R_IDLE);

    assign w_arm_ok    = w_arm && w_rnd_idle && !w_abort;
    assign w_render_ok = w_render && r_captured && w_rnd_idle && !w_abort && !w_arm;
    assign w_auto_go   = (r_cstate == C_DONE) && r_auto && w_rnd_idle && !w_abort && !w_arm;
    assign w_raw_ok    = data_write && (address == 4'h4) && w_rnd_idle && !w_abort
                         && !w_render_ok && !w_auto_go;

    assign w_presc_next = (data_write && (address == 4'h1)) ? data_in[3:0] : r_presc_cfg;

    assign w_idle   = (r_cstate == C_IDLE) && w_rnd_idle;
    assign w_armed  = (r_cstate == C_ARMED) || (r_cstate == C_RUN);
    assign data_out = (address == 4'h0) ? {4'b0000, !w_rnd_idle, r_captured, w_armed, w_idle}
                                        : 8'h00;
    assign uo_out   = {3'b000, r_dc, r_cs_n, r_shreg[7], r_sck, 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc_cfg <= 4'd4;
            r_mark      <= 1'b0;
            r_trig      <= 5'd0;
            r_sdiv      <= 8'd0;
            r_auto      <= 1'b0;
            r_man_dc    <= 1'b0;
            r_man_cs_n  <= 1'b1;
            r_raw_byte  <= 8'd0;
        end else if (data_write) begin
            case (address)
                4'h0: r_auto <= data_in[2];
                4'h1: begin
                    r_presc_cfg <= data_in[3:0];
                    r_mark      <= data_in[4];
                end
                4'h2: r_trig <= data_in[4:0];
                4'h3: r_sdiv <= data_in;
                4'h4: if (w_raw_ok) r_raw_byte <= data_in;
                4'h5: begin
                    r_man_dc   <= data_in[0];
                    r_man_cs_n <= data_in[1];
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Capture: edge trigger on the selected channel, then decimated store
    // ------------------------------------------------------------------
    assign w_cur_s      = ui_in[r_trig[2:0]];
    assign w_edge       = r_trig[3] ? (r_prev_ui[r_trig[2:0]] && !w_cur_s)
                                    : (!r_prev_ui[r_trig[2:0]] && w_cur_s);
    assign w_fire       = r_trig[4] || w_edge;
    assign w_sample_due = (r_div == r_sdiv);
    assign w_store      = rst_n && !w_abort && !w_arm_ok &&
                          (((r_cstate == C_ARMED) && w_fire) ||
                           ((r_cstate == C_RUN) && w_sample_due));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cstate   <= C_IDLE;
            r_captured <= 1'b0;
            r_widx     <= '0;
            r_div      <= 8'd0;
            r_prev_ui  <= 8'd0;
        end else begin
            r_prev_ui <= ui_in;
            if (w_abort) begin
                r_cstate <= C_IDLE;
            end else if (w_arm_ok) begin
                r_cstate   <= C_ARMED;
                r_captured <= 1'b0;
                r_widx     <= '0;
                r_div      <= 8'd0;
            end else begin
                case (r_cstate)
                    C_ARMED: if (w_fire) begin
                        r_widx   <= AW'(1);
                        r_div    <= 8'd0;
                        r_cstate <= C_RUN;
                    end
                    C_RUN: if (w_sample_due) begin
                        r_div  <= 8'd0;
                        r_widx <= r_widx + AW'(1);
                        if (r_widx == AW'(DEPTH - 1)) begin
                            r_cstate   <= C_DONE;
                            r_captured <= 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                    C_DONE:  r_cstate <= C_IDLE;
                    default: r_cstate <= C_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_widx] <= ui_in[NUM_CH-1:0];
    end

    // ------------------------------------------------------------------
    // Byte source for the current render step (channel, phase, index)
    // ------------------------------------------------------------------
    assign w_idx_prev  = r_idx - AW'(1);
    assign w_prev_s    = r_mem[w_idx_prev][r_ch];
    assign w_last_byte = r_raw || (r_phase && (r_idx == AW'(DEPTH - 1)) &&
                                   (r_ch == CHW'(NUM_CH - 1)));

    always_comb begin
        w_byte = 8'h00;
        if (r_raw) begin
            w_byte = r_raw_byte;
        end else if (!r_phase) begin
            case (r_idx[2:0])
                3'd0:    w_byte = 8'h22;
                3'd1:    w_byte = 8'(PAGE_BASE) + 8'(r_ch);
                3'd2:    w_byte = 8'(PAGE_BASE) + 8'(r_ch);
                3'd3:    w_byte = 8'h21;
                3'd4:    w_byte = 8'h00;
                default: w_byte = 8'(DEPTH - 1);
            endcase
        end else if (r_mark && (r_idx != '0) && (r_mem[r_idx][r_ch] != w_prev_s)) begin
            w_byte = 8'hFF;
        end else begin
            w_byte = r_mem[r_idx][r_ch] ? 8'h80 : 8'h01;
        end
    end

    // ------------------------------------------------------------------
    // Render sequencer and SPI shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rstate    <= R_IDLE;
            r_sck       <= SPI_CPOL;
            r_shreg     <= 8'd0;
            r_cs_n      <= 1'b1;
            r_dc        <= 1'b0;
            r_presc_act <= 4'd4;
            r_cnt       <= 4'd0;
            r_half      <= 4'd0;
            r_ch        <= '0;
            r_phase     <= 1'b0;
            r_idx       <= '0;
            r_raw       <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            // a new prescaler only takes hold between bytes
            if (r_rstate != R_SHIFT) r_presc_act <= w_presc_next;
            if (w_abort) begin
                r_rstate <= R_IDLE;
                r_sck    <= SPI_CPOL;
                r_shreg  <= 8'd0;
                r_cs_n   <= r_man_cs_n;
                r_dc     <= r_man_dc;
            end else begin
                case (r_rstate)
                    R_IDLE: begin
                        r_cs_n <= r_man_cs_n;
                        r_dc   <= r_man_dc;
                        if (w_render_ok || w_auto_go) begin
                            r_ch     <= '0;
                            r_phase  <= 1'b0;
                            r_idx    <= '0;
                            r_raw    <= 1'b0;
                            r_rstate <= R_LOAD;
                        end else if (w_raw_ok) begin
                            r_raw    <= 1'b1;
                            r_rstate <= R_LOAD;
                        end
                    end
                    R_LOAD: begin
                        r_shreg <= w_byte;
                        r_cs_n  <= 1'b0;
                        if (!r_raw) r_dc <= r_phase;
                        r_cnt    <= 4'd0;
                        r_half   <= 4'd0;
                        r_rstate <= R_SHIFT;
                    end
                    R_SHIFT: begin
                        if (r_cnt == r_presc_act) begin
                            r_cnt  <= 4'd0;
                            r_half <= r_half + 4'd1;
                            if (!r_half[0]) begin
                                r_sck <= ~SPI_CPOL;
                            end else begin
                                r_sck   <= SPI_CPOL;
                                r_shreg <= {r_shreg[6:0], 1'b0};
                            end
                            if (r_half == 4'd15) begin
                                r_rstate <= R_GAP;
                                r_last   <= w_last_byte;
                                if (!w_last_byte) begin
                                    if (!r_phase) begin
                                        if (r_idx == AW'(5)) begin
                                            r_phase <= 1'b1;
                                            r_idx   <= '0;
                                        end else begin
                                            r_idx <= r_idx + AW'(1);
                                        end
                                    end else if (r_idx == AW'(DEPTH - 1)) begin
                                        r_phase <= 1'b0;
                                        r_idx   <= '0;
                                        r_ch    <= r_ch + CHW'(1);
                                    end else begin
                                        r_idx <= r_idx + AW'(1);
                                    end
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    R_GAP: begin
                        // after the final byte, hold CS low one more prescaler tick
                        if (!r_last) begin
                            r_rstate <= R_LOAD;
                        end else if (r_cnt == r_presc_act) begin
                            r_cs_n   <= r_man_cs_n;
                            r_dc     <= r_man_dc;
                            r_rstate <= R_DONE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    R_DONE:  r_rstate <= R_IDLE;
                    default: r_rstate <= R_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/tqvp_waveform_capture_plotter.md
Name: tqvp_waveform_capture_plotter

Overview:
TinyQV peripheral that captures NUM_CH digital channels from ui_in into an on-chip sample buffer, using a configurable edge trigger and sample divider. It then renders each channel as a one-page track on an SSD1306 OLED over SPI. This generalises the single-byte pixel plotter: channel count, buffer depth and SPI clock polarity are parameters, and trigger, autonomous capture and transition markers are new. It sits in the peripheral slot and uses the standard 4-bit address / 8-bit data register interface.

Parameters:
NUM_CH, 4, number of captured channels (1..8) = ui_in[NUM_CH-1:0]; channel c is drawn on OLED page PAGE_BASE+c
DEPTH, 128, samples per channel = display columns (power of two, 8..128)
PAGE_BASE, 0, OLED page of channel 0; PAGE_BASE+NUM_CH must be <= 8
SPI_CPOL, 0, SCK idle level

Ports:
clk  in  1  peripheral clock (64 MHz nominal)
rst_n  in  1  reset; synchronous, active-low; clock clk
ui_in  in  8  input PMOD, already synchronised; bits [NUM_CH-1:0] are sampled
uo_out  out  8  [1]=SCK, [2]=MOSI, [3]=CS_N, [4]=DC, all other bits 0
address  in  4  register address
data_write  in  1  write strobe, one cycle
data_in  in  8  write data
data_out  out  8  read data (combinational from address)

Behaviour:
- Register writes:
  - 0x0 CTRL (self-clearing): [0] ARM, [1] RENDER, [2] AUTO (sticky copy, render after capture), [3] ABORT.
  - 0x1 CFG: [3:0] PRESC, [4] MARK (transition marker enable).
  - 0x2 TRIG: [2:0] channel, [3] 0=rising / 1=falling, [4] IMMEDIATE.
  - 0x3 SDIV[7:0]: one sample every SDIV+1 clk.
  - 0x4 RAW: send data_in as one SPI byte with the current DC.
  - 0x5 MAN: [0] DC, [1] CS_N manual level, both used only while render is idle.
- Register reads: address 0x0 = {4'b0, rendering, captured, armed, idle}; idle = both FSMs idle. Other addresses read 0.
- Reset values: SCK=SPI_CPOL, MOSI=0, CS_N=1, DC=0, PRESC=4, SDIV=0, TRIG=0, MARK=0, AUTO=0, both FSMs IDLE, captured=0.
- Capture FSM states: C_IDLE, C_ARMED, C_RUN, C_DONE.
  - ARM from any state except while rendering: go to C_ARMED, clear captured and the write index. ARM while rendering is ignored.
  - C_ARMED: the trigger channel's previous and current values are compared every clk. On the selected edge, store sample 0 = ui_in in the same cycle, then go to C_RUN. IMMEDIATE=1 triggers on the cycle after ARM.
  - C_RUN: store one sample per SDIV+1 clk. After sample DEPTH-1 is stored, go to C_DONE and set captured. Capture length with SDIV=0 is exactly DEPTH clk.
  - C_DONE: if AUTO=1, render starts on the next clk.
- Render FSM states: R_IDLE, R_LOAD, R_SHIFT, R_GAP, R_DONE. It is driven by a step counter (channel, phase, column).
  - RENDER is accepted only if captured=1 and render is idle; otherwise it is ignored.
  - Per channel c: DC=0, send 0x22, PAGE_BASE+c, PAGE_BASE+c, 0x21, 0x00, DEPTH-1. Then DC=1, send DEPTH column bytes.
  - Column byte for sample i: 0x80 if the sample is high, 0x01 if low. If MARK=1, i>0 and sample i differs from sample i-1, the byte is 0xFF.
  - CS_N=0 from R_LOAD of the first byte until one PRESC tick after the last byte. Then CS_N returns to the MAN level and DC returns to MAN.DC.
  - After the last channel, go to R_DONE, then R_IDLE. captured stays 1, so the buffer can be re-rendered.
- SPI engine:
  - MSB first. Each half SCK period lasts PRESC+1 clk, so one byte takes 16*(PRESC+1) clk.
  - The first leading edge comes PRESC+1 clk after R_LOAD. MOSI changes only on trailing edges and is valid before the first leading edge.
  - SCK=SPI_CPOL whenever no byte is shifting.
  - Exactly 1 idle clk (R_GAP) between consecutive bytes; DC changes only in R_GAP/R_LOAD.
  - RAW uses the same engine; RAW while busy is ignored.
- ABORT takes priority over every other event, including a simultaneous ARM or RENDER. Next clk: both FSMs idle, SCK=SPI_CPOL, CS_N=MAN level, the shift register is cleared, and captured is preserved.
- CFG/TRIG/SDIV writes take effect immediately, except PRESC: a PRESC write is deferred while a byte is shifting and applies from the next byte.
- Reset mid-transfer returns all outputs to their reset values on the next clk edge; no partial byte is completed.

Test Plan:
- Reset, then read 0x0 -> 0x01; uo_out = {3'b0, DC=0, CS_N=1, MOSI=0, SCK=0, 0}.
- PRESC=0, RAW 0xA5 -> 16 clk of SCK toggling every clk; MOSI bits 1,0,1,0,0,1,0,1 sampled on rising edges; CS_N=0 only during the transfer.
- TRIG=0x00 (ch0 rising), SDIV=0, ARM; drive ui_in[0] 0->1 at cycle T -> sample 0 taken at T; captured set at T+DEPTH-1; status reads 0x05.
- Square wave on ch1 with period 8 clk, MARK=1, AUTO=1 -> page PAGE_BASE+1 receives command bytes 0x22,0x01,0x01,0x21,0x00,0x7F, then 128 data bytes with 0xFF at every 4th column and 0x80/0x01 elsewhere.
- RENDER with captured=0 -> ignored, status stays 0x01; ARM during render -> ignored, render byte count is unchanged.
- ABORT in the middle of a render byte -> next clk SCK=0 and CS_N=1; a following RENDER re-renders the same buffer from channel 0.
